// File: rtl/fpu_divsqrt_arb.sv
// Round-robin arbiter and sequencer sharing one iterative FDIV/FSQRT unit among NUM_REQ requesters.
// Holds one operation at a time, drives the unit handshakes and returns the result to its owner.
package fpu_divsqrt_arb_pkg;
  localparam int unsigned FPU_OP_NUM = 2;
  localparam int unsigned OP_FDIV    = 0;
  localparam int unsigned OP_FSQRT   = 1;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4,
    RM_DYN = 3'd7
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;
endpackage

module fpu_divsqrt_arb
  import fpu_divsqrt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned FLEN    = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_flush,
  input  logic [NUM_REQ-1:0]                    i_req_valid,
  output logic [NUM_REQ-1:0]                    o_req_ready,
  input  logic [NUM_REQ-1:0][3:1][FLEN-1:0]     i_req_rs,
  input  logic [NUM_REQ-1:0][FPU_OP_NUM-1:0]    i_req_op,
  input  roundmode_e [NUM_REQ-1:0]              i_req_rm,
  output logic [NUM_REQ-1:0]                    o_rsp_valid,
  input  logic [NUM_REQ-1:0]                    i_rsp_ready,
  output logic [FLEN-1:0]                       o_rsp_result,
  output fflags_t                               o_rsp_fflags,
  output logic                                  o_du_valid,
  input  logic                                  i_du_ready,
  output logic [3:1][FLEN-1:0]                  o_du_rs,
  output logic [FPU_OP_NUM-1:0]                 o_du_op,
  output roundmode_e                            o_du_rm,
  input  logic                                  i_du_valid,
  output logic                                  o_du_ready,
  input  logic [FLEN-1:0]                       i_du_result,
  input  fflags_t                               i_du_fflags,
  output logic                                  o_busy
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           rr_ptr_q, owner_q, win_idx, ptr_next;
  logic [PW:0]             scan_idx;
  logic                    win_found;
  logic                    accept, capture, ptr_upd, drop_set, drop_clr, drop_q;
  logic [NUM_REQ-1:0]      req_ready, rsp_valid;
  logic                    du_valid, du_ready;
  logic [3:1][FLEN-1:0]    rs_q;
  logic [FPU_OP_NUM-1:0]   op_q;
  roundmode_e              rm_q;
  logic [FLEN-1:0]         result_q;
  fflags_t                 fflags_q;

  // First valid requester scanning upward from rr_ptr, wrapping by compare-and-subtract
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(NUM_REQ)) scan_idx = scan_idx - (PW+1)'(NUM_REQ);
      if (!win_found && i_req_valid[scan_idx[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PW-1:0];
      end
    end
  end

  assign ptr_next = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    du_valid  = 1'b0;
    du_ready  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    ptr_upd   = 1'b0;
    drop_set  = 1'b0;
    drop_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && !i_flush) begin
          req_ready[win_idx] = 1'b1;
          accept             = 1'b1;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        if (i_flush) begin
          ptr_upd = 1'b1;
          state_d = IDLE;
        end else begin
          du_valid = 1'b1;
          if (i_du_ready) state_d = WAIT;
        end
      end
      WAIT: begin
        du_ready = 1'b1;
        if (i_flush) ptr_upd = 1'b1;
        // A flushed op still has to drain its result out of the unit
        if (i_du_valid) begin
          capture  = 1'b1;
          drop_clr = 1'b1;
          state_d  = (i_flush || drop_q) ? IDLE : RESP;
        end else if (i_flush) begin
          drop_set = 1'b1;
        end
      end
      RESP: begin
        if (i_flush) begin
          ptr_upd = 1'b1;
          state_d = IDLE;
        end else begin
          rsp_valid[owner_q] = 1'b1;
          if (i_rsp_ready[owner_q]) begin
            ptr_upd = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      drop_q   <= 1'b0;
      rs_q     <= '0;
      op_q     <= '0;
      rm_q     <= RM_RNE;
      result_q <= '0;
      fflags_q <= '0;
    end else begin
      if (accept) begin
        rs_q    <= i_req_rs[win_idx];
        op_q    <= i_req_op[win_idx];
        rm_q    <= i_req_rm[win_idx];
        owner_q <= win_idx;
      end
      if (capture) begin
        result_q <= i_du_result;
        fflags_q <= i_du_fflags;
      end
      if (ptr_upd) rr_ptr_q <= ptr_next;
      if (drop_clr)      drop_q <= 1'b0;
      else if (drop_set) drop_q <= 1'b1;
    end
  end

  // Grant is combinational on i_req_valid, so it is also masked while reset is asserted
  assign o_req_ready  = i_rst ? '0 : req_ready;
  assign o_rsp_valid  = rsp_valid;
  assign o_du_valid   = du_valid;
  assign o_du_ready   = du_ready;
  assign o_du_rs      = rs_q;
  assign o_du_op      = op_q;
  assign o_du_rm      = rm_q;
  assign o_rsp_result = result_q;
  assign o_rsp_fflags = fflags_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_divsqrt_arb.sv
// Self-checking bench for fpu_divsqrt_arb: directed vector table, reset corner case, and
// randomized ops checked against a transaction-level round-robin model.
module tb_fpu_divsqrt_arb;
  import fpu_divsqrt_arb_pkg::*;

  localparam int unsigned N    = 2;
  localparam int unsigned FLEN = 32;

  logic                        clk, rst, flush;
  logic [N-1:0]                req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][3:1][FLEN-1:0] req_rs;
  logic [N-1:0][1:0]           req_op;
  roundmode_e [N-1:0]          req_rm;
  logic [FLEN-1:0]             rsp_result, du_result;
  fflags_t                     rsp_fflags, du_fflags;
  logic                        unit_in_valid, unit_in_ready, unit_out_valid, unit_out_ready;
  logic [3:1][FLEN-1:0]        du_rs;
  logic [1:0]                  du_op;
  roundmode_e                  du_rm;
  logic                        busy;

  int checks   = 0;
  int failures = 0;
  int model_ptr = 0;

  fpu_divsqrt_arb #(.NUM_REQ(N), .FLEN(FLEN)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_rs(req_rs), .i_req_op(req_op), .i_req_rm(req_rm),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_fflags(rsp_fflags),
    .o_du_valid(unit_in_valid), .i_du_ready(unit_in_ready),
    .o_du_rs(du_rs), .o_du_op(du_op), .o_du_rm(du_rm),
    .i_du_valid(unit_out_valid), .o_du_ready(unit_out_ready),
    .i_du_result(du_result), .i_du_fflags(du_fflags),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] vmask;
    logic [31:0]  rs1;
    logic [31:0]  rs2;
    int           dly_rdy;
    int           lat;
    int           dly_rsp;
    int           fl;       // 0 none, 1 flush in ISSUE, 2 flush in WAIT, 3 flush in RESP
    logic [31:0]  res;
    logic [4:0]   ff;
    int           exp_w;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference round-robin: first valid index starting at ptr, modulo N
  function automatic int model_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic scramble();
    for (int k = 0; k < N; k++) begin
      req_rs[k] = {$urandom, $urandom, $urandom};
      req_op[k] = 2'(1 << $urandom_range(0, 1));
      req_rm[k] = roundmode_e'($urandom_range(0, 4));
    end
  endtask

  task automatic run_op(input logic [N-1:0] vmask, input logic [31:0] rs1, input logic [31:0] rs2,
                        input int dly_rdy, input int lat, input int dly_rsp, input int fl,
                        input logic [31:0] res, input logic [4:0] ff, input int exp_w);
    logic [95:0] exp_rs;
    logic [1:0]  exp_op;
    roundmode_e  exp_rm;
    scramble();
    req_rs[exp_w][1] = rs1;
    req_rs[exp_w][2] = rs2;
    exp_rs = req_rs[exp_w];
    exp_op = req_op[exp_w];
    exp_rm = req_rm[exp_w];
    req_valid = vmask; flush = 1'b0; unit_in_ready = 1'b0; unit_out_valid = 1'b0; rsp_ready = '0;
    settle();
    chk("grant", req_ready, oh(exp_w));
    step();
    req_valid = '0;
    scramble();
    for (int d = 0; d < dly_rdy; d++) begin
      settle();
      chk("issue_hold_valid", unit_in_valid, 1'b1);
      chk("issue_hold_rs", du_rs, exp_rs);
      step();
      scramble();
    end
    unit_in_ready = 1'b1;
    flush = (fl == 1);
    settle();
    chk("issue_valid", unit_in_valid, fl != 1);
    chk("issue_rs", du_rs, exp_rs);
    chk("issue_op", du_op, exp_op);
    chk("issue_rm", du_rm, exp_rm);
    step();
    unit_in_ready = 1'b0;
    flush = 1'b0;
    if (fl == 1) begin
      settle();
      chk("flush_issue_idle", busy, 1'b0);
      model_ptr = (exp_w + 1) % N;
      return;
    end
    flush = (fl == 2);
    for (int d = 0; d < lat; d++) begin
      settle();
      chk("wait_du_ready", unit_out_ready, 1'b1);
      chk("wait_no_rsp", rsp_valid, '0);
      step();
      flush = 1'b0;
    end
    unit_out_valid = 1'b1; du_result = res; du_fflags = fflags_t'(ff);
    settle();
    chk("drain_du_ready", unit_out_ready, 1'b1);
    chk("rsp_not_comb", rsp_valid, '0);
    step();
    unit_out_valid = 1'b0; du_result = $urandom; du_fflags = fflags_t'(5'($urandom));
    if (fl == 2) begin
      settle();
      chk("flush_wait_no_rsp", rsp_valid, '0);
      chk("flush_wait_idle", busy, 1'b0);
      model_ptr = (exp_w + 1) % N;
      return;
    end
    req_valid = '1;
    rsp_ready = ~oh(exp_w);
    for (int d = 0; d < dly_rsp; d++) begin
      settle();
      chk("resp_hold_valid", rsp_valid, oh(exp_w));
      chk("resp_hold_result", rsp_result, res);
      chk("resp_hold_fflags", rsp_fflags, ff);
      chk("resp_no_grant", req_ready, '0);
      step();
    end
    if (fl == 3) begin
      flush = 1'b1;
      settle();
      chk("flush_resp_drop", rsp_valid, '0);
      step();
      flush = 1'b0; rsp_ready = '0; req_valid = '0;
      settle();
      chk("flush_resp_idle", busy, 1'b0);
      model_ptr = (exp_w + 1) % N;
      return;
    end
    rsp_ready = oh(exp_w);
    settle();
    chk("resp_valid", rsp_valid, oh(exp_w));
    chk("resp_result", rsp_result, res);
    chk("resp_fflags", rsp_fflags, ff);
    step();
    rsp_ready = '0; req_valid = '0;
    settle();
    chk("resp_done_idle", busy, 1'b0);
    model_ptr = (exp_w + 1) % N;
  endtask

  initial begin
    //           vmask  rs1           rs2           rdy lat rsp fl res           ff    exp
    tbl[0]  = '{2'b10, 32'h40400000, 32'h40000000, 0, 10, 0, 0, 32'h3FC00000, 5'h00, 1};
    tbl[1]  = '{2'b11, 32'h3F800000, 32'h40000000, 0,  1, 0, 0, 32'h3F000000, 5'h00, 0};
    tbl[2]  = '{2'b11, 32'h41000000, 32'h40800000, 1,  2, 1, 0, 32'h40000000, 5'h00, 1};
    tbl[3]  = '{2'b11, 32'h40800000, 32'h00000000, 0,  3, 0, 0, 32'h40000000, 5'h00, 0};
    tbl[4]  = '{2'b11, 32'h3F800000, 32'h00000000, 2,  1, 2, 0, 32'h7F800000, 5'h08, 1};
    tbl[5]  = '{2'b11, 32'hBF800000, 32'h00000000, 0,  4, 0, 0, 32'h7FC00000, 5'h10, 0};
    tbl[6]  = '{2'b11, 32'h40000000, 32'h00000000, 1,  1, 1, 0, 32'h3FB504F3, 5'h01, 1};
    tbl[7]  = '{2'b01, 32'h12345678, 32'h9ABCDEF0, 5,  2, 3, 0, 32'hCAFEF00D, 5'h01, 0};
    tbl[8]  = '{2'b11, 32'h40400000, 32'h40000000, 0,  4, 0, 2, 32'h3FC00000, 5'h00, 1};
    tbl[9]  = '{2'b11, 32'h40400000, 32'h40000000, 0,  1, 0, 1, 32'h3FC00000, 5'h00, 0};
    tbl[10] = '{2'b01, 32'h40400000, 32'h40000000, 0,  2, 1, 3, 32'h3FC00000, 5'h00, 0};
    tbl[11] = '{2'b11, 32'h40E00000, 32'h40000000, 0,  1, 0, 0, 32'h40600000, 5'h00, 1};
    tbl[12] = '{2'b10, 32'h3F800000, 32'h40400000, 0,  2, 0, 0, 32'h3EAAAAAB, 5'h01, 1};
    tbl[13] = '{2'b01, 32'h41800000, 32'h00000000, 0,  1, 0, 0, 32'h40800000, 5'h00, 0};

    rst = 1'b1; flush = 1'b0; req_valid = 2'b11; rsp_ready = '0;
    unit_in_ready = 1'b0; unit_out_valid = 1'b0; du_result = '0; du_fflags = '0;
    scramble();
    #2;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_du_valid", unit_in_valid, 1'b0);
    chk("rst_du_ready", unit_out_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_du_rs", du_rs, '0);
    chk("rst_result", rsp_result, '0);
    step();
    step();
    rst = 1'b0; req_valid = '0;

    for (int t = 0; t < 14; t++)
      run_op(tbl[t].vmask, tbl[t].rs1, tbl[t].rs2, tbl[t].dly_rdy, tbl[t].lat,
             tbl[t].dly_rsp, tbl[t].fl, tbl[t].res, tbl[t].ff, tbl[t].exp_w);

    // Async reset while waiting on the unit; rr_ptr is 1 going in
    scramble();
    req_valid = 2'b01;
    settle();
    chk("arst_grant", req_ready, 2'b01);
    step();
    req_valid = '0; unit_in_ready = 1'b1;
    settle();
    chk("arst_issue", unit_in_valid, 1'b1);
    step();
    unit_in_ready = 1'b0;
    settle();
    chk("arst_in_wait", unit_out_ready, 1'b1);
    req_valid = 2'b11;
    #1 rst = 1'b1;
    #1;
    chk("arst_req_ready", req_ready, '0);
    chk("arst_du_ready", unit_out_ready, 1'b0);
    chk("arst_du_valid", unit_in_valid, 1'b0);
    chk("arst_rsp_valid", rsp_valid, '0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_du_rs", du_rs, '0);
    step();
    rst = 1'b0; req_valid = '0;
    model_ptr = 0;
    run_op(2'b11, 32'h40400000, 32'h40000000, 0, 2, 0, 0, 32'h3FC00000, 5'h00, 0);

    for (int it = 0; it < 40; it++) begin
      logic [N-1:0] vm;
      int           w;
      int           fl;
      vm = N'($urandom_range(1, (1 << N) - 1));
      w  = model_winner(vm, model_ptr);
      fl = ($urandom_range(0, 5) < 4) ? 0 : int'($urandom_range(1, 3));
      run_op(vm, $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 5)),
             int'($urandom_range(0, 3)), fl, $urandom, 5'($urandom), w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
